// File: rtl/tiger_debug_tx.sv
// CPU-to-host debug channel: an Avalon-written word FIFO feeding a host-clocked
// shift engine that sends a valid flag followed by the word, LSB first, on host_tdo.
module tiger_debug_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_debugSlave_address,
    input  logic        avs_debugSlave_write,
    input  logic [31:0] avs_debugSlave_writedata,
    input  logic        avs_debugSlave_read,
    output logic [31:0] avs_debugSlave_readdata,
    output logic        avs_debugSlave_irq,
    input  logic        host_capture,
    input  logic        host_shift,
    output logic        host_tdo,
    output logic        host_busy
);

    localparam int PTR_WIDTH = CNT_WIDTH - 1;
    localparam int BIT_WIDTH = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] BIT_ONE  = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] LAST_BIT = BIT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shiftState_e;

    logic [DATA_WIDTH-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wrPtr;
    logic [PTR_WIDTH-1:0]  rdPtr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  irqEn;

    shiftState_e           state;
    logic [DATA_WIDTH:0]   sr;
    logic [BIT_WIDTH-1:0]  bitCnt;
    logic                  irqReg;

    logic        fifoEmpty;
    logic        fifoFull;
    logic        busy;
    logic        pushReq;
    logic        ctrlWrite;
    logic        doPop;
    logic        doPush;
    logic        setOverflow;
    logic [31:0] statusWord;
    logic        unusedRead;

    // Avalon slave has zero wait states: a write is accepted on every cycle its
    // strobe is high, and readdata is valid in the same cycle as the address.
    assign unusedRead = avs_debugSlave_read;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULL_CNT);
    assign busy      = (state == SHIFT);

    assign pushReq   = avs_debugSlave_write && !avs_debugSlave_address;
    assign ctrlWrite = avs_debugSlave_write &&  avs_debugSlave_address;

    // A capture only pops what was already queued before this edge.
    assign doPop       = host_capture && !fifoEmpty;
    assign doPush      = pushReq && (!fifoFull || doPop);
    assign setOverflow = pushReq && fifoFull && !doPop;

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr] <= avs_debugSlave_writedata[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irqEn    <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A fresh overflow outranks a simultaneous clear.
            if (setOverflow) begin
                overflow <= 1'b1;
            end else if (ctrlWrite && avs_debugSlave_writedata[1]) begin
                overflow <= 1'b0;
            end
            if (ctrlWrite) begin
                irqEn <= avs_debugSlave_writedata[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            bitCnt <= '0;
            irqReg <= 1'b0;
        end else begin
            irqReg <= irqEn && fifoEmpty && !busy;
            if (host_capture) begin
                bitCnt <= '0;
                if (!fifoEmpty) begin
                    sr    <= {fifoMem[rdPtr], 1'b1};
                    state <= SHIFT;
                end else begin
                    sr    <= '0;
                    state <= IDLE;
                end
            end else if (host_shift) begin
                sr <= {1'b0, sr[DATA_WIDTH:1]};
                if (state == SHIFT) begin
                    bitCnt <= bitCnt + BIT_ONE;
                    // The last data bit lands on sr[0] on this edge.
                    if (bitCnt == LAST_BIT) begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

    always_comb begin
        statusWord                 = '0;
        statusWord[8 +: CNT_WIDTH] = count;
        statusWord[3]              = busy;
        statusWord[2]              = overflow;
        statusWord[1]              = fifoFull;
        statusWord[0]              = fifoEmpty;
    end

    assign avs_debugSlave_readdata = avs_debugSlave_address ? {31'b0, irqEn} : statusWord;
    assign avs_debugSlave_irq      = irqReg;
    assign host_tdo                = sr[0];
    assign host_busy               = busy;

endmodule

// File: tb/tb_tiger_debug_tx.sv
// Directed bench for tiger_debug_tx: FIFO push/pop, serial framing, overflow,
// IRQ timing, aborts and mid-frame reset, each step checked against hand values.
module tb_tiger_debug_tx;

    logic        clk;
    logic        reset;
    logic        address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        irq;
    logic        host_capture;
    logic        host_shift;
    logic        host_tdo;
    logic        host_busy;

    int nVec;
    int nErr;

    tiger_debug_tx #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(8),
        .CNT_WIDTH (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .avs_debugSlave_address  (address),
        .avs_debugSlave_write    (write),
        .avs_debugSlave_writedata(writedata),
        .avs_debugSlave_read     (read),
        .avs_debugSlave_readdata (readdata),
        .avs_debugSlave_irq      (irq),
        .host_capture            (host_capture),
        .host_shift              (host_shift),
        .host_tdo                (host_tdo),
        .host_busy               (host_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuWrite(input logic a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        tick();
        write     = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic a, input logic [31:0] exp);
        address = a;
        read    = 1'b1;
        #1;
        check(tag, readdata, exp);
        read    = 1'b0;
    endtask

    task automatic capture();
        host_capture = 1'b1;
        tick();
        host_capture = 1'b0;
    endtask

    task automatic shift();
        host_shift = 1'b1;
        tick();
        host_shift = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] got;
        nVec         = 0;
        nErr         = 0;
        reset        = 1'b0;
        address      = 1'b0;
        write        = 1'b0;
        writedata    = '0;
        read         = 1'b0;
        host_capture = 1'b0;
        host_shift   = 1'b0;

        // Reset values
        applyReset();
        readCheck("rst_status", 1'b0, 32'h0000_0001);
        readCheck("rst_ctrl", 1'b1, 32'h0000_0000);
        check("rst_irq", irq, 0);
        check("rst_tdo", host_tdo, 0);
        check("rst_busy", host_busy, 0);

        // Single word frame
        word = 32'hA5A5_0001;
        cpuWrite(1'b0, word);
        readCheck("push1_status", 1'b0, 32'h0000_0100);
        capture();
        check("frame_valid", host_tdo, 1);
        check("frame_busy", host_busy, 1);
        readCheck("frame_status", 1'b0, 32'h0000_0009);
        for (int k = 1; k <= 32; k++) begin
            shift();
            check("frame_bit", host_tdo, word[k-1]);
            check("frame_busy_k", host_busy, (k < 32) ? 1 : 0);
        end
        readCheck("frame_done_status", 1'b0, 32'h0000_0001);

        // Capture on an empty FIFO
        capture();
        check("empty_cap_tdo", host_tdo, 0);
        check("empty_cap_busy", host_busy, 0);
        readCheck("empty_cap_status", 1'b0, 32'h0000_0001);

        // Overflow on the ninth push, W1C clear, in-order drain
        for (int i = 0; i < 9; i++) begin
            cpuWrite(1'b0, 32'h1000_0000 + i);
        end
        readCheck("ovf_status", 1'b0, 32'h0000_0806);
        cpuWrite(1'b1, 32'h0000_0002);
        readCheck("ovf_clr_status", 1'b0, 32'h0000_0802);
        readCheck("ovf_clr_ctrl", 1'b1, 32'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            capture();
            check("drain_valid", host_tdo, 1);
            got = '0;
            for (int k = 0; k < 32; k++) begin
                shift();
                got[k] = host_tdo;
            end
            check("drain_word", got, 32'h1000_0000 + i);
        end
        readCheck("drain_status", 1'b0, 32'h0000_0001);

        // IRQ timing
        cpuWrite(1'b1, 32'h0000_0001);
        check("irq_en_edge", irq, 0);
        tick();
        check("irq_idle_empty", irq, 1);
        cpuWrite(1'b0, 32'h5A5A_5A5A);
        check("irq_push_edge", irq, 1);
        tick();
        check("irq_after_push", irq, 0);
        capture();
        check("irq_capture", irq, 0);
        for (int k = 1; k <= 32; k++) begin
            shift();
        end
        check("irq_busy_fall", irq, 0);
        check("irq_busy_low", host_busy, 0);
        tick();
        check("irq_rise", irq, 1);
        cpuWrite(1'b1, 32'h0000_0000);
        check("irq_dis_edge", irq, 1);
        tick();
        check("irq_dis", irq, 0);

        // Push and pop together while full: no overflow
        for (int i = 0; i < 8; i++) begin
            cpuWrite(1'b0, 32'h20 + i);
        end
        readCheck("full_status", 1'b0, 32'h0000_0802);
        host_capture = 1'b1;
        address      = 1'b0;
        write        = 1'b1;
        writedata    = 32'h99;
        tick();
        host_capture = 1'b0;
        write        = 1'b0;
        readCheck("full_pushpop_status", 1'b0, 32'h0000_080A);
        check("full_pushpop_tdo", host_tdo, 1);
        applyReset();

        // Push racing a capture on an empty FIFO stays queued
        host_capture = 1'b1;
        address      = 1'b0;
        write        = 1'b1;
        writedata    = 32'h77;
        tick();
        host_capture = 1'b0;
        write        = 1'b0;
        check("race_tdo", host_tdo, 0);
        readCheck("race_status", 1'b0, 32'h0000_0100);
        capture();
        check("race_cap_tdo", host_tdo, 1);
        readCheck("race_cap_status", 1'b0, 32'h0000_0009);
        shift();
        check("race_bit0", host_tdo, 1);
        applyReset();

        // Mid-frame capture aborts the first word, then reset mid-frame
        word = 32'h1111_2222;
        cpuWrite(1'b0, word);
        cpuWrite(1'b0, 32'h3333_4445);
        capture();
        check("abort_valid1", host_tdo, 1);
        readCheck("abort_status1", 1'b0, 32'h0000_0108);
        for (int k = 1; k <= 10; k++) begin
            shift();
            check("abort_bit", host_tdo, word[k-1]);
        end
        capture();
        check("abort_valid2", host_tdo, 1);
        check("abort_busy2", host_busy, 1);
        readCheck("abort_status2", 1'b0, 32'h0000_0009);
        shift();
        check("abort_w2_bit0", host_tdo, 1);
        shift();
        check("abort_w2_bit1", host_tdo, 0);
        reset = 1'b1;
        tick();
        readCheck("midrst_status", 1'b0, 32'h0000_0001);
        readCheck("midrst_ctrl", 1'b1, 32'h0000_0000);
        check("midrst_tdo", host_tdo, 0);
        check("midrst_busy", host_busy, 0);
        check("midrst_irq", irq, 0);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
